// File: rtl/bus_peripheral.sv
// Memory-mapped peripheral block on the MEM-stage data bus. It holds an interval timer
// with interrupt, an LED register, a 4-digit hex seven-segment scanner and a cycle counter.
module bus_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic        irq,
  output logic [11:0] digi
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  localparam logic [2:0] REG_TH   = 3'd0;
  localparam logic [2:0] REG_TL   = 3'd1;
  localparam logic [2:0] REG_TCON = 3'd2;
  localparam logic [2:0] REG_LED  = 3'd3;
  localparam logic [2:0] REG_DISP = 3'd4;
  localparam logic [2:0] REG_TICK = 3'd5;

  logic [31:0]      th_q, th_d, tl_q, tl_d, tick_q, tick_d;
  logic [2:0]       tcon_q, tcon_d;
  logic [7:0]       led_q, led_d;
  logic [15:0]      disp_q, disp_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             irq_q, irq_d;
  logic [11:0]      digi_q, digi_d;

  logic       hit, wr_hit, overflow, ovf_set;
  logic [2:0] sel;
  logic [3:0] nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign hit    = (addr[31:5] == BASE_ADDR[31:5]);
  assign sel    = addr[4:2];
  assign wr_hit = wr && hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    th_d       = th_q;
    tl_d       = tl_q;
    led_d      = led_q;
    disp_d     = disp_q;
    tick_d     = tick_q + 32'd1;
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;

    overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    ovf_set  = overflow && tcon_q[1];
    if (tcon_q[0]) tl_d = overflow ? th_q : tl_q + 32'd1;
    tcon_d = {tcon_q[2] | ovf_set, tcon_q[1:0]};

    // Bus writes are applied last so they override the timer's own update.
    if (wr_hit) begin
      case (sel)
        REG_TH:   th_d   = wdata;
        REG_TL:   tl_d   = wdata;
        REG_TCON: tcon_d = {wdata[2] | ovf_set, wdata[1:0]};
        REG_LED:  led_d  = wdata[7:0];
        REG_DISP: disp_d = wdata[15:0];
        default:  ;
      endcase
    end
    irq_d = tcon_d[1] & tcon_d[2];

    if (scan_cnt_q == CNT_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    // Display is built from next-state values so anodes and segments stay aligned.
    case (idx_d)
      2'd0:    nibble = disp_d[3:0];
      2'd1:    nibble = disp_d[7:4];
      2'd2:    nibble = disp_d[11:8];
      default: nibble = disp_d[15:12];
    endcase
    digi_d = {~(4'b0001 << idx_d), 1'b1, hex_to_seg(nibble)};
  end

  always_comb begin
    rdata = 32'h0;
    if (rd && hit) begin
      case (sel)
        REG_TH:   rdata = th_q;
        REG_TL:   rdata = tl_q;
        REG_TCON: rdata = {29'h0, tcon_q};
        REG_LED:  rdata = {24'h0, led_q};
        REG_DISP: rdata = {16'h0, disp_q};
        REG_TICK: rdata = tick_q;
        default:  rdata = 32'h0;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q       <= '0;
      tl_q       <= '0;
      tcon_q     <= '0;
      led_q      <= '0;
      disp_q     <= '0;
      tick_q     <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      irq_q      <= 1'b0;
      digi_q     <= 12'b1110_1_1000000;
    end else begin
      th_q       <= th_d;
      tl_q       <= tl_d;
      tcon_q     <= tcon_d;
      led_q      <= led_d;
      disp_q     <= disp_d;
      tick_q     <= tick_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      irq_q      <= irq_d;
      digi_q     <= digi_d;
    end
  end

  assign led  = led_q;
  assign irq  = irq_q;
  assign digi = digi_q;

endmodule

// File: tb/tb_bus_peripheral.sv
// Self-checking bench for bus_peripheral: directed scenarios plus a randomized bus run,
// all compared against a register-level behavioural model of the peripheral.
module tb_bus_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          DIV  = 4;

  logic        clk = 1'b0;
  logic        reset, rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic        irq;
  logic [11:0] digi;

  int errors = 0;
  int checks = 0;

  bus_peripheral #(.BASE_ADDR(BASE), .SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led(led), .irq(irq), .digi(digi)
  );

  always #10 clk = ~clk;

  // Model state, named after the software-visible registers.
  logic [31:0] m_th, m_tl, m_tick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [15:0] m_disp;
  logic        m_irq;
  int          m_cyc;
  logic [6:0]  seg_tab [16];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    case (a[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'h0, m_tcon};
      3'd3: return {24'h0, m_led};
      3'd4: return {16'h0, m_disp};
      3'd5: return m_tick;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [11:0] model_digi();
    int         digit;
    logic [3:0] nib;
    digit = (m_cyc / DIV) % 4;
    nib   = 4'((m_disp >> (4 * digit)) & 16'hF);
    return {~(4'(1) << digit), 1'b1, seg_tab[nib]};
  endfunction

  // Advances the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    logic        hit, ovf, set_st;
    logic [31:0] n_tl;
    logic [2:0]  n_tcon;
    if (reset) begin
      m_th = 0; m_tl = 0; m_tick = 0; m_tcon = 0; m_led = 0; m_disp = 0; m_irq = 0; m_cyc = 0;
      return;
    end
    hit    = (addr[31:5] == BASE[31:5]);
    ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    set_st = ovf && m_tcon[1];
    n_tl   = !m_tcon[0] ? m_tl : (ovf ? m_th : m_tl + 1);
    n_tcon = m_tcon;
    if (set_st) n_tcon[2] = 1'b1;
    if (wr && hit) begin
      case (addr[4:2])
        3'd0: m_th   = wdata;
        3'd1: n_tl   = wdata;
        3'd2: n_tcon = {wdata[2] | set_st, wdata[1:0]};
        3'd3: m_led  = wdata[7:0];
        3'd4: m_disp = wdata[15:0];
        default: ;
      endcase
    end
    m_tl   = n_tl;
    m_tcon = n_tcon;
    m_irq  = m_tcon[1] & m_tcon[2];
    m_tick = m_tick + 1;
    m_cyc  = m_cyc + 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a, exp;
    reset = 1'b1; wr = 1'b1; addr = BASE + 32'h0C; wdata = 32'hFF;
    step();
    step();
    reset = 1'b0; wr = 1'b0;
    for (int o = 0; o < 8; o++) begin
      a = BASE + 32'(o * 4);
      exp = model_read(a);
      rd = 1'b1; addr = a; #1;
      checks++;
      if (rdata !== exp) begin
        errors++; $display("FAIL reset_read off=%0h: got %h expected %h", o * 4, rdata, exp);
      end
    end
    rd = 1'b0;
    checks++;
    if (digi !== 12'hEC0 || led !== 8'h00 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: digi=%h led=%h irq=%b expected EC0/00/0", digi, led, irq);
    end
  endtask

  task automatic test_led();
    logic [31:0] d;
    bus_write(BASE + 32'h0C, 32'h0000_01A5);
    checks++;
    if (led !== 8'hA5) begin errors++; $display("FAIL led_write: got %h expected a5", led); end
    rd = 1'b1; addr = BASE + 32'h0C; #1;
    checks++;
    if (rdata !== 32'h0000_00A5) begin errors++; $display("FAIL led_read: got %h expected 000000a5", rdata); end
    addr = 32'h5000_000C; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL out_of_window: got %h expected 0", rdata); end
    rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = $urandom();
      bus_write(BASE + 32'h0C, d);
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL led_rand[%0d]: got %h expected %h", i, led, m_led); end
    end
  endtask

  task automatic test_timer();
    logic [31:0] exp_tl [3];
    exp_tl[0] = 32'hFFFF_FFFE; exp_tl[1] = 32'hFFFF_FFFF; exp_tl[2] = 32'hFFFF_FFFC;
    bus_write(BASE + 32'h00, 32'hFFFF_FFFC);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h08, 32'h3);
    rd = 1'b1; addr = BASE + 32'h04;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdata !== exp_tl[i]) begin errors++; $display("FAIL timer_tl[%0d]: got %h expected %h", i, rdata, exp_tl[i]); end
      if (i < 2) step();
    end
    addr = BASE + 32'h08; #1;
    checks++;
    if (rdata !== 32'h7 || irq !== m_irq || irq !== 1'b1) begin
      errors++; $display("FAIL timer_ovf: tcon=%h irq=%b expected 7/1", rdata, irq);
    end
    bus_write(BASE + 32'h08, 32'h3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL timer_clear: irq=%b expected 0", irq); end
  endtask

  task automatic test_same_cycle();
    bus_write(BASE + 32'h08, 32'h3);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h08, 32'h3);
    rd = 1'b1; addr = BASE + 32'h08; #1;
    checks++;
    if (rdata !== 32'h7 || irq !== 1'b1) begin
      errors++; $display("FAIL same_cycle_set: tcon=%h irq=%b expected 7/1", rdata, irq);
    end
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h04, 32'h0000_1234);
    rd = 1'b1; addr = BASE + 32'h04; #1;
    checks++;
    if (rdata !== 32'h0000_1234) begin errors++; $display("FAIL tl_write_wins: got %h expected 00001234", rdata); end
    rd = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] anode_exp [4];
    logic [6:0] seg_exp [4];
    int digit;
    anode_exp[0] = 4'hE; anode_exp[1] = 4'hD; anode_exp[2] = 4'hB; anode_exp[3] = 4'h7;
    seg_exp[0] = 7'b1000000; seg_exp[1] = 7'b1111001; seg_exp[2] = 7'b0001110; seg_exp[3] = 7'b0000000;
    reset = 1'b1; step(); reset = 1'b0;
    bus_write(BASE + 32'h10, 32'h0000_8F10);
    for (int c = 1; c < 20; c++) begin
      digit = (c / DIV) % 4;
      checks++;
      if (digi !== {anode_exp[digit], 1'b1, seg_exp[digit]} || digi !== model_digi()) begin
        errors++; $display("FAIL scan cyc=%0d: got %h expected %h", c, digi, {anode_exp[digit], 1'b1, seg_exp[digit]});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    bus_write(BASE + 32'h08, 32'h3);
    step();
    reset = 1'b1; wr = 1'b1; addr = BASE + 32'h0C; wdata = 32'h5A;
    step();
    reset = 1'b0; wr = 1'b0;
    rd = 1'b1; addr = BASE + 32'h04; #1;
    checks++;
    if (rdata !== 32'h0 || irq !== 1'b0 || led !== 8'h0) begin
      errors++; $display("FAIL reset_mid: tl=%h irq=%b led=%h expected 0/0/0", rdata, irq, led);
    end
    addr = BASE + 32'h14; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_tick: got %h expected 0", rdata); end
    rd = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      addr = ($urandom_range(0, 9) == 0) ? $urandom() : BASE + 32'($urandom_range(0, 31));
      wdata = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      if (addr[4:2] == 3'd2 && $urandom_range(0, 1) == 1) wdata[0] = 1'b1;
      #1;
      exp = rd ? model_read(addr) : 32'h0;
      checks++;
      if (rdata !== exp) begin errors++; $display("FAIL rand_read[%0d] addr=%h: got %h expected %h", i, addr, rdata, exp); end
      step();
      checks++;
      if (led !== m_led || irq !== m_irq || digi !== model_digi()) begin
        errors++; $display("FAIL rand_out[%0d]: led=%h irq=%b digi=%h expected %h/%b/%h", i, led, irq, digi, m_led, m_irq, model_digi());
      end
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010; seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    m_cyc = 0;
    test_reset();
    test_led();
    test_timer();
    test_same_cycle();
    test_scan();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
